// File: rtl/data_router_pkg.sv
// Shared types and constants for the data_router sequencer.
package data_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    PW = 1'b0,
    DW = 1'b1
  } mode_e;

  localparam int BANKW = 2;
  localparam int ROWW  = 2;

  // Column advance between consecutive depthwise tiles.
  function automatic int unsigned dw_col_step(input int unsigned pox, input int unsigned stride);
    return pox * stride;
  endfunction

endpackage

// File: rtl/data_router_ctrl_cnt.sv
// Loop counter: counts 0..term_i, wraps to 0, clear has priority over enable.
module router_loop_cnt #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == term_i);
  assign cnt_o  = cnt_q;

  // Next count: clear, advance, or wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_router_ctrl.sv
// Input-buffer read address sequencer for data_router (depthwise / pointwise).
//
// Handshake: addr_valid=1 presents bank/row/col/rpsel/blkend. An address is
// consumed on a rising edge where addr_valid=1 and stall=0. If stall=1 on that
// edge the address is not consumed: it is held with addr_valid=0 and presented
// again with addr_valid=1 one cycle after stall is seen low.
module data_router_ctrl
  import data_router_pkg::*;
#(
  parameter int POX    = 16,
  parameter int POY    = 3,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 2,
  parameter int COLW   = 28,
  parameter int CNTW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNTW-1:0]  cfg_ntile,
  input  logic [CNTW-1:0]  cfg_ncol,
  input  logic [CNTW-1:0]  cfg_nblk,
  input  logic             stall,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             addr_valid,
  output logic [BANKW-1:0] bank,
  output logic [ROWW-1:0]  row,
  output logic [COLW-1:0]  col,
  output logic [ROWW-1:0]  rpsel,
  output logic             blkend,
  output logic             dw_comp,
  output state_e           state_dbg,
  output logic [CNTW-1:0]  blk_dbg
);

  localparam logic [ROWW-1:0]  K_TERM    = ROWW'(KSIZE - 1);
  localparam logic [COLW-1:0]  COL_STEP  = COLW'(dw_col_step(POX, STRIDE));
  localparam logic [BANKW-1:0] BANK_LAST = BANKW'(POY - 1);

  // A zero count is treated as one, so the terminal value is max(v,1)-1.
  function automatic logic [CNTW-1:0] cfg_term(input logic [CNTW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  state_e           state_q;
  mode_e            mode_q;
  logic             busy_q, done_q, valid_q;
  logic [BANKW-1:0] bank_q;
  logic [COLW-1:0]  col_q;
  logic [CNTW-1:0]  tile_term_q, blk_term_q;

  logic [ROWW-1:0]  kx_cnt, ky_cnt;
  logic [CNTW-1:0]  tile_cnt, blk_cnt;
  logic             kx_wrap, ky_wrap, tile_wrap, blk_wrap;
  logic             is_dw, start_acc, abort_acc, adv, blk_last, cnt_clr;
  logic             kx_en, ky_en, tile_en, blk_en;

  assign is_dw     = (mode_q == DW);
  assign start_acc = (state_q == IDLE) && start && !abort;
  assign abort_acc = (state_q != IDLE) && abort;
  // The presented address is consumed this edge.
  assign adv       = (state_q == RUN) && valid_q && !stall && !abort;
  assign blk_last  = tile_wrap && (!is_dw || (kx_wrap && ky_wrap));
  assign cnt_clr   = start_acc || abort_acc;

  assign kx_en   = adv && is_dw;
  assign ky_en   = adv && is_dw && kx_wrap;
  assign tile_en = adv && (!is_dw || (kx_wrap && ky_wrap));
  assign blk_en  = adv && blk_last;

  router_loop_cnt #(.W(ROWW)) u_kx (
    .clk_i(clk), .rst_ni(rst_n), .en_i(kx_en), .clr_i(cnt_clr),
    .term_i(K_TERM), .cnt_o(kx_cnt), .wrap_o(kx_wrap)
  );

  router_loop_cnt #(.W(ROWW)) u_ky (
    .clk_i(clk), .rst_ni(rst_n), .en_i(ky_en), .clr_i(cnt_clr),
    .term_i(K_TERM), .cnt_o(ky_cnt), .wrap_o(ky_wrap)
  );

  router_loop_cnt #(.W(CNTW)) u_tile (
    .clk_i(clk), .rst_ni(rst_n), .en_i(tile_en), .clr_i(cnt_clr),
    .term_i(tile_term_q), .cnt_o(tile_cnt), .wrap_o(tile_wrap)
  );

  router_loop_cnt #(.W(CNTW)) u_blk (
    .clk_i(clk), .rst_ni(rst_n), .en_i(blk_en), .clr_i(cnt_clr),
    .term_i(blk_term_q), .cnt_o(blk_cnt), .wrap_o(blk_wrap)
  );

  // Pass sequencing FSM with registered status, bank and depthwise column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= PW;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      bank_q      <= '0;
      col_q       <= '0;
      tile_term_q <= '0;
      blk_term_q  <= '0;
    end else if (abort_acc) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      bank_q  <= '0;
      col_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_acc) begin
            state_q     <= RUN;
            mode_q      <= mode_e'(mode);
            busy_q      <= 1'b1;
            valid_q     <= 1'b1;
            bank_q      <= '0;
            col_q       <= '0;
            tile_term_q <= mode ? cfg_term(cfg_ntile) : cfg_term(cfg_ncol);
            blk_term_q  <= cfg_term(cfg_nblk);
          end
        end
        RUN: begin
          if (stall) begin
            valid_q <= 1'b0;
          end else if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (blk_last) begin
            col_q <= '0;
            if (blk_wrap) begin
              state_q <= FLUSH;
              valid_q <= 1'b0;
            end else begin
              bank_q <= (bank_q == BANK_LAST) ? '0 : bank_q + 1'b1;
            end
          end else if (is_dw && kx_wrap && ky_wrap) begin
            col_q <= col_q + COL_STEP;
          end
        end
        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign addr_valid = valid_q;
  assign bank       = bank_q;
  assign row        = ky_cnt;
  assign rpsel      = kx_cnt;
  assign col        = is_dw ? col_q : COLW'(tile_cnt);
  assign blkend     = valid_q && blk_last;
  assign dw_comp    = is_dw;
  assign state_dbg  = state_q;
  assign blk_dbg    = blk_cnt;

endmodule

// File: tb/tb_data_router_ctrl.sv
// Directed testbench for data_router_ctrl.
module tb_data_router_ctrl;
  import data_router_pkg::*;

  localparam int COLW = 28;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0, mode = 1'b0, stall = 1'b0, abort = 1'b0;
  logic [CNTW-1:0] cfg_ntile = '0, cfg_ncol = '0, cfg_nblk = '0;
  logic            busy, done, addr_valid, blkend, dw_comp;
  logic [1:0]      bank, row, rpsel;
  logic [COLW-1:0] col;
  state_e          state_dbg;
  logic [CNTW-1:0] blk_dbg;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  data_router_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .cfg_ntile(cfg_ntile), .cfg_ncol(cfg_ncol), .cfg_nblk(cfg_nblk),
    .stall(stall), .abort(abort),
    .busy(busy), .done(done), .addr_valid(addr_valid),
    .bank(bank), .row(row), .col(col), .rpsel(rpsel),
    .blkend(blkend), .dw_comp(dw_comp),
    .state_dbg(state_dbg), .blk_dbg(blk_dbg)
  );

  // Scoreboard helpers
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [34:0] cur_addr();
    return {bank, row, col, rpsel, blkend};
  endfunction

  function automatic logic [37:0] outs();
    return {busy, done, addr_valid, bank, row, col, rpsel, blkend};
  endfunction

  task automatic chk_addr(input string tag);
    logic [34:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
    chk(tag, {29'd0, cur_addr()}, {29'd0, e});
  endtask

  // Expected depthwise block (nblk=1): col = t*POX*STRIDE = t*32.
  task automatic push_dw(input int nt);
    for (int t = 0; t < nt; t++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          exp_q.push_back({2'd0, 2'(ky), COLW'(t * 32), 2'(kx),
                           (t == nt - 1 && ky == 2 && kx == 2)});
  endtask

  task automatic push_pw(input int nc, input int nb);
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < nc; c++)
        exp_q.push_back({2'(b % 3), 2'd0, COLW'(c), 2'd0, (c == nc - 1)});
  endtask

  // Driver tasks
  task automatic do_start(input logic m, input int nt, input int nc, input int nb);
    @(posedge clk); #1;
    mode      = m;
    cfg_ntile = CNTW'(nt);
    cfg_ncol  = CNTW'(nc);
    cfg_nblk  = CNTW'(nb);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    int acc;
    int stall_cnt;
    bit stalled_once, seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 64'(outs()), 64'd0);
    chk("rst_dw_comp", 64'(dw_comp), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(IDLE));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", 64'(outs()), 64'd0);

    // 1: depthwise, ntile=2, nblk=1
    push_dw(2);
    do_start(1'b1, 2, 0, 1);
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      chk("t1_valid", 64'(addr_valid), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_dw_comp", 64'(dw_comp), 64'd1);
      chk_addr("t1_addr");
    end
    @(negedge clk);
    chk("t1_flush", 64'({busy, done, addr_valid, blkend}), 64'b1000);
    chk("t1_flush_state", 64'(state_dbg), 64'(FLUSH));
    @(negedge clk);
    chk("t1_done", 64'({busy, done, addr_valid}), 64'b110);
    @(negedge clk);
    chk("t1_idle", 64'({busy, done, addr_valid}), 64'b000);
    chk("t1_dw_comp_hold", 64'(dw_comp), 64'd1);

    // 2: pointwise, ncol=5, nblk=4
    push_pw(5, 4);
    do_start(1'b0, 0, 5, 4);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk("t2_valid", 64'(addr_valid), 64'd1);
      chk_addr("t2_addr");
    end
    chk("t2_dw_comp", 64'(dw_comp), 64'd0);
    @(negedge clk);
    chk("t2_flush", 64'({busy, done, addr_valid}), 64'b100);
    @(negedge clk);
    chk("t2_done", 64'({busy, done, addr_valid}), 64'b110);
    @(negedge clk);
    chk("t2_idle", 64'(outs() & 38'h3800000000), 64'd0);

    // 3: depthwise ntile=1, stall 3 cycles on (row=1,rpsel=1)
    push_dw(1);
    do_start(1'b1, 1, 0, 1);
    acc = 0; stall_cnt = 0; stalled_once = 1'b0; seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      if (stall) begin
        chk("t3_stall_valid", 64'(addr_valid), 64'd0);
        chk("t3_hold", 64'({row, rpsel}), 64'b0101);
        stall_cnt++;
        if (stall_cnt == 3) stall = 1'b0;
      end else if (addr_valid) begin
        if (!stalled_once && row == 2'd1 && rpsel == 2'd1) begin
          stall = 1'b1;
          stalled_once = 1'b1;
        end else begin
          acc++;
          chk_addr("t3_addr");
        end
      end
    end
    chk("t3_accepted", 64'(acc), 64'd9);
    chk("t3_stalled", 64'(stall_cnt), 64'd3);
    chk("t3_done", 64'(seen), 64'd1);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("t3_idle", 64'(busy), 64'd0);

    // 4: abort at the 4th pointwise address
    exp_q.delete();
    push_pw(5, 2);
    do_start(1'b0, 0, 5, 2);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk_addr("t4_addr");
    end
    abort = 1'b1;
    @(negedge clk);
    chk("t4_abort_outs", 64'(outs()), 64'd0);
    chk("t4_abort_state", 64'(state_dbg), 64'(IDLE));
    abort = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy || addr_valid) seen = 1'b1;
    end
    chk("t4_no_done", 64'(seen), 64'd0);
    exp_q.delete();
    push_pw(2, 1);
    do_start(1'b0, 0, 2, 1);
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      chk_addr("t4_restart_addr");
    end
    wait_done("t4_restart_done", 6);
    @(negedge clk);

    // 5: cfg zero treated as one; start during busy ignored
    exp_q.delete();
    exp_q.push_back({2'd0, 2'd0, COLW'(0), 2'd0, 1'b1});
    do_start(1'b0, 0, 0, 0);
    @(negedge clk);
    chk("t5_valid", 64'(addr_valid), 64'd1);
    chk_addr("t5_addr");
    start = 1'b1;
    @(negedge clk);
    chk("t5_flush", 64'({busy, done, addr_valid}), 64'b100);
    @(negedge clk);
    chk("t5_done", 64'({busy, done, addr_valid}), 64'b110);
    start = 1'b0;
    @(negedge clk);
    chk("t5_idle", 64'({busy, done, addr_valid}), 64'b000);
    @(negedge clk);
    chk("t5_still_idle", 64'({busy, addr_valid, state_dbg}), 64'(IDLE));

    // 6: asynchronous reset mid depthwise pass
    do_start(1'b1, 2, 0, 1);
    repeat (5) @(negedge clk);
    chk("t6_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", 64'(outs()), 64'd0);
    chk("t6_rst_dw_comp", 64'(dw_comp), 64'd0);
    chk("t6_rst_state", 64'(state_dbg), 64'(IDLE));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy || addr_valid || done) seen = 1'b1;
    end
    chk("t6_idle_after_rst", 64'(seen), 64'd0);
    exp_q.delete();
    push_dw(1);
    do_start(1'b1, 1, 0, 1);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      chk_addr("t6_restart_addr");
    end
    wait_done("t6_restart_done", 6);
    @(negedge clk);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
